// File: rtl/core_sequencer_pkg.sv
// Shared sequencer codes: FSM state encodings, trap causes
// and the default bus timeout.
package core_sequencer_pkg;

    // Sequencer states, 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_WB    = 3'd4,
        ST_HALT  = 3'd5
    } seq_state_e;

    // Trap cause codes reported on trap_cause
    typedef enum logic [1:0] {
        TRAP_NONE = 2'b00,
        TRAP_ILL  = 2'b01,
        TRAP_IMEM = 2'b10,
        TRAP_DMEM = 2'b11
    } trap_cause_e;

    localparam int unsigned SEQ_TIMEOUT_DEFAULT = 255;
    localparam int unsigned WAIT_W              = 8;

    // States in which a bus request is outstanding
    function automatic logic is_bus_state(input seq_state_e s);
        return (s == ST_FETCH) || (s == ST_MEM);
    endfunction

endpackage

// File: rtl/core_sequencer_bus_wait_timer.sv
// Bus wait timer shared by FETCH and MEM: counts cycles
// without an ack and flags when the limit is reached.
module core_sequencer_bus_wait_timer
    import core_sequencer_pkg::*;
#(
    parameter int unsigned LIMIT = SEQ_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [WAIT_W-1:0] LIMIT_C = WAIT_W'(LIMIT);
    localparam logic [WAIT_W-1:0] MAX_C   = '1;

    logic [WAIT_W-1:0] count_q;
    logic [WAIT_W-1:0] count_d;

    // Next count: clear wins, saturate at the top
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != MAX_C)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LIMIT_C);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I sequencer: fetch, exec, mem, write-back,
// with bus timeouts, illegal-instruction trap and retire counter.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = SEQ_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    input  logic        ill_instr,
    input  logic        mem_write_enable,
    input  logic        mem_to_reg,
    input  logic        reg_write_enable,
    output logic        imem_req,
    output logic        ir_load,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        mdr_load,
    output logic        rf_we,
    output logic        pc_update,
    output logic        pc_reset,
    output logic        halt,
    output logic [1:0]  trap_cause,
    output logic [31:0] retire_count
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("core_sequencer: TIMEOUT must be 1..255");
    end

    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("core_sequencer: RESET_PC must be word aligned");
    end

    seq_state_e  state_q;
    seq_state_e  state_d;
    trap_cause_e trap_q;
    trap_cause_e trap_d;
    logic [31:0] retire_q;
    logic [31:0] retire_d;
    logic        started_q;
    logic        pc_reset_q;
    logic        boot_done;
    logic        wait_clear;
    logic        wait_en;
    logic        wait_expired;

    // Ack wait timer, reused by FETCH and MEM
    assign wait_clear = !is_bus_state(state_q);
    assign wait_en    = ((state_q == ST_FETCH) && !imem_ack)
                     || ((state_q == ST_MEM) && !dmem_ack);

    core_sequencer_bus_wait_timer #(
        .LIMIT (TIMEOUT)
    ) u_wait (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_i   (wait_clear),
        .enable_i  (wait_en),
        .expired_o (wait_expired)
    );

    // PC reset pulse: one cycle after the first edge out of reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            started_q  <= 1'b0;
            pc_reset_q <= 1'b0;
        end else begin
            started_q  <= 1'b1;
            pc_reset_q <= !started_q;
        end
    end

    // Issue is held back until the PC has been reset
    assign boot_done = started_q && !pc_reset_q;

    // State, trap cause and retire counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            trap_q   <= TRAP_NONE;
            retire_q <= '0;
        end else begin
            state_q  <= state_d;
            trap_q   <= trap_d;
            retire_q <= retire_d;
        end
    end

    // Next-state, trap capture and retire increment
    always_comb begin
        state_d  = state_q;
        trap_d   = trap_q;
        retire_d = retire_q;
        unique case (state_q)
            ST_IDLE: begin
                if (run && boot_done) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    state_d = ST_EXEC;
                end else if (wait_expired) begin
                    state_d = ST_HALT;
                    trap_d  = TRAP_IMEM;
                end
            end
            ST_EXEC: begin
                if (ill_instr) begin
                    state_d = ST_HALT;
                    trap_d  = TRAP_ILL;
                end else if (mem_write_enable || mem_to_reg) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    state_d = ST_WB;
                end else if (wait_expired) begin
                    state_d = ST_HALT;
                    trap_d  = TRAP_DMEM;
                end
            end
            ST_WB: begin
                retire_d = retire_q + 32'd1;
                state_d  = run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // Output decode: Moore, plus ack-qualified load strobes
    always_comb begin
        imem_req  = 1'b0;
        ir_load   = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        mdr_load  = 1'b0;
        rf_we     = 1'b0;
        pc_update = 1'b0;
        pc_reset  = 1'b0;
        halt      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                pc_reset = pc_reset_q;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ack;
            end
            ST_EXEC: begin
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = mem_write_enable;
                mdr_load = dmem_ack && mem_to_reg;
            end
            ST_WB: begin
                rf_we     = reg_write_enable;
                pc_update = 1'b1;
            end
            ST_HALT: begin
                halt = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign trap_cause   = trap_q;
    assign retire_count = retire_q;

endmodule
